// File: rtl/iter_stream.sv
// iter_stream: walks an index from 0 to MAX_VALUE once per start request and
// presents each index as a valid/ready beat, flagging the final beat with
// `last` and following the pass with a one-cycle `done` pulse.
// Optional feature: define ITER_STREAM_ABORT_EN to add the `abort` input,
// which cancels a pass in progress without a `done` pulse.
module iter_stream #(
  parameter int MAX_VALUE = 15,
  parameter int WIDTH     = (MAX_VALUE < 1) ? 1 : $clog2(MAX_VALUE + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic [WIDTH-1:0] val,
  output logic             valid,
  input  logic             ready,
  output logic             last,
  output logic             done
`ifdef ITER_STREAM_ABORT_EN
  ,
  input  logic             abort
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] MAX_IDX = WIDTH'(MAX_VALUE);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             last_q, last_d;
  logic             done_q, done_d;
  logic             xfer;

  assign xfer = valid_q && ready;

  // Next-state logic; every output is computed one cycle ahead so it leaves a flop.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    last_d  = last_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          idx_d   = '0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          last_d  = (MAX_IDX == '0);
        end
      end
      RUN: begin
        if (xfer) begin
          if (idx_q == MAX_IDX) begin
            state_d = FIN;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d  = idx_q + WIDTH'(1);
            last_d = ((idx_q + WIDTH'(1)) == MAX_IDX);
          end
        end
`ifdef ITER_STREAM_ABORT_EN
        // Abort overrides everything, including a coincident final transfer.
        if (abort) begin
          state_d = IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          last_d  = 1'b0;
          done_d  = 1'b0;
        end
`endif
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  // State and output registers, cleared asynchronously while reset is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign val   = idx_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign last  = last_q;
  assign done  = done_q;

endmodule
